// File: rtl/mod2777_pkg.sv
// Shared definitions for the mod-2777 datapath: the operand multiplier
// (mulq_iter_2777) and the Barrett reduction stage it feeds. Both ends
// import this package so they agree on the modulus and the product width.
package mod2777_pkg;

  localparam int Q  = 2777;  // modulus; operands are folded below Q
  localparam int W  = 12;    // operand width
  localparam int PW = 23;    // product width, 2*W-1; (Q-1)^2 < 2^PW

  typedef logic [W-1:0]  res_t;   // operand / residue
  typedef logic [PW-1:0] prod_t;  // full product handed to the reducer

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/mulq_iter_2777_if.sv
// Handshake bundle for mulq_iter_2777.
//   in_valid/in_ready/in_a/in_b  : operand pair, upstream -> block
//   out_valid/out_ready/out_p    : product, block -> downstream
//   out_fix                      : at least one operand of this product was folded
//   busy                         : block is iterating on a product
// slave  : the multiplier block
// master : the upstream/downstream environment
interface mulq_iter_2777_if;
  import mod2777_pkg::*;

  logic  in_valid;
  logic  in_ready;
  res_t  in_a;
  res_t  in_b;
  logic  out_valid;
  logic  out_ready;
  prod_t out_p;
  logic  out_fix;
  logic  busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_fix, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_fix, busy
  );

endinterface

// File: rtl/mulq_iter_2777_fold_q.sv
// fold_q: combinational conditional subtract that maps 0..4095 into 0..Q-1.
// A single subtract suffices because 2^W - 1 < 2*Q.
//   x  : raw operand
//   y  : folded operand
//   ge : x was >= Q (a fold happened)
module fold_q
  import mod2777_pkg::*;
(
  input  res_t x,
  output res_t y,
  output logic ge
);

  always_comb begin
    ge = (x >= res_t'(Q));
    y  = ge ? (x - res_t'(Q)) : x;
  end

endmodule

// File: rtl/mulq_iter_2777.sv
// mulq_iter_2777: folds two 12-bit operands below Q = 2777 and multiplies
// them with an iterative shift-add datapath consuming RB multiplier bits per
// cycle. The 23-bit product is held on a valid/ready output for the
// downstream Barrett reducer.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any product in flight
//   bus   : handshake bundle (slave side), see mulq_iter_2777_if
// Latency is W/RB cycles from accept to out_valid; a new pair can be
// accepted in the same cycle the previous product transfers.
module mulq_iter_2777
  import mod2777_pkg::*;
#(
  parameter int RB = 1  // multiplier bits per busy cycle: 1, 2, 3, 4 or 6
) (
  input  logic               clk,
  input  logic               rst_n,
  mulq_iter_2777_if.slave    bus
);

  localparam int             ND   = W / RB;   // digits per product
  localparam int             CW   = 4;        // holds ND-1 for every legal RB
  localparam logic [CW-1:0]  LAST = CW'(ND - 1);

  state_e          state, state_nxt;
  prod_t           mcand, acc, acc_nxt, pp, out_p_q;
  res_t            mplier;
  logic [CW-1:0]   cnt;
  logic            fix_q, out_fix_q;
  logic            rdy_en;     // low during reset, high from the first edge after it
  logic            accept;
  logic            last_digit;

  res_t            a_f, b_f;
  logic            a_ge, b_ge;

  fold_q u_fold_a (.x(bus.in_a), .y(a_f), .ge(a_ge));
  fold_q u_fold_b (.x(bus.in_b), .y(b_f), .ge(b_ge));

  assign accept     = bus.in_valid & bus.in_ready;
  assign last_digit = (cnt == LAST);

  // Partial product is truncated to PW; the final sum never exceeds (Q-1)^2.
  assign pp      = mcand * prod_t'(mplier[RB-1:0]);
  assign acc_nxt = acc + pp;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (last_digit) state_nxt = DONE;
      DONE: begin
        if (accept)             state_nxt = BUSY;  // back-to-back pair
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: bus.in_ready = rdy_en;
      BUSY: bus.busy     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;  // accept only alongside the transfer
      end
      default: ;
    endcase
  end

  assign bus.out_p   = out_p_q;
  assign bus.out_fix = out_fix_q;

  // Shift-add datapath. The fold flag is captured at accept but only exposed
  // together with its product, so out_p/out_fix always describe the same pair.
  // NOTE: these are plain registers, not a memory array, so all of them take
  // the async reset and an aborted product can never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      fix_q     <= 1'b0;
      out_p_q   <= '0;
      out_fix_q <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        mcand  <= prod_t'(a_f);
        mplier <= b_f;
        acc    <= '0;
        cnt    <= '0;
        fix_q  <= a_ge | b_ge;
      end else if (state == BUSY) begin
        acc    <= acc_nxt;
        mcand  <= mcand << RB;
        mplier <= mplier >> RB;
        cnt    <= cnt + CW'(1);
        if (last_digit) begin
          out_p_q   <= acc_nxt;
          out_fix_q <= fix_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mulq_iter_2777.sv
// Self-checking bench for mulq_iter_2777. Two instances (RB=1 and RB=4) share
// the stimulus variables; 'sel' routes in_valid to one of them and selects
// which one's outputs are observed. Expected results come from modular
// arithmetic on the raw operands.
module tb_mulq_iter_2777;
  import mod2777_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  sel;          // 0: RB=1 instance, 1: RB=4 instance
  logic  in_valid;
  res_t  in_a, in_b;
  logic  out_ready;

  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  mulq_iter_2777_if u1_if ();
  mulq_iter_2777_if u4_if ();

  assign u1_if.in_valid  = in_valid & ~sel;
  assign u1_if.in_a      = in_a;
  assign u1_if.in_b      = in_b;
  assign u1_if.out_ready = out_ready;
  assign u4_if.in_valid  = in_valid & sel;
  assign u4_if.in_a      = in_a;
  assign u4_if.in_b      = in_b;
  assign u4_if.out_ready = out_ready;

  mulq_iter_2777 #(.RB(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u1_if.slave));
  mulq_iter_2777 #(.RB(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(u4_if.slave));

  logic  o_in_ready, o_out_valid, o_out_fix, o_busy;
  prod_t o_out_p;
  assign o_in_ready  = sel ? u4_if.in_ready  : u1_if.in_ready;
  assign o_out_valid = sel ? u4_if.out_valid : u1_if.out_valid;
  assign o_out_fix   = sel ? u4_if.out_fix   : u1_if.out_fix;
  assign o_busy      = sel ? u4_if.busy      : u1_if.busy;
  assign o_out_p     = sel ? u4_if.out_p     : u1_if.out_p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: folding 0..4095 once is the same as reducing mod Q.
  function automatic int unsigned ref_prod(input int unsigned a, input int unsigned b);
    return (a % Q) * (b % Q);
  endfunction

  function automatic bit ref_fix(input int unsigned a, input int unsigned b);
    return (a >= Q) || (b >= Q);
  endfunction

  // One complete transaction with out_ready held high.
  task automatic run_op(input int unsigned a, input int unsigned b, input string tag);
    int n;
    int lat;
    lat = sel ? 3 : 12;
    n = 0;
    while (!o_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, ".in_ready"}, 32'(o_in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = res_t'(a);
    in_b     = res_t'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!o_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".out_p"},   32'(o_out_p), ref_prod(a, b));
    check({tag, ".out_fix"}, 32'(o_out_fix), 32'(ref_fix(a, b)));
    @(posedge clk); #1;
    check({tag, ".valid_drop"}, 32'(o_out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int unsigned exp_a, exp_b;

    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(o_out_valid), 32'd0);
    check("rst.out_p",     32'(o_out_p),     32'd0);
    check("rst.out_fix",   32'(o_out_fix),   32'd0);
    check("rst.busy",      32'(o_busy),      32'd0);
    check("rst.in_ready",  32'(o_in_ready),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.in_ready_after", 32'(o_in_ready), 32'd1);

    // Max folded operands, folding, zero/identity on RB=1.
    run_op(2776, 2776, "max");
    run_op(3000, 2,    "fold_a");
    run_op(4095, 4095, "fold_both");
    run_op(0,    1234, "zero");
    run_op(1,    1,    "one");

    // Backpressure: first pair stalls on output while second pair waits.
    exp_a = ref_prod(100, 200);
    exp_b = ref_prod(300, 4000);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_a = 12'd100; in_b = 12'd200;
    @(posedge clk); #1;
    in_a = 12'd300; in_b = 12'd4000;
    n = 0;
    while (!o_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp.latency", 32'(n), 32'd12);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp.hold_p",     32'(o_out_p),     exp_a);
      check("bp.hold_valid", 32'(o_out_valid), 32'd1);
      check("bp.in_ready",   32'(o_in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.in_ready_release", 32'(o_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.b2b_busy",  32'(o_busy),      32'd1);
    check("bp.b2b_valid", 32'(o_out_valid), 32'd0);
    n = 0;
    while (!o_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp.second_latency", 32'(n),         32'd12);
    check("bp.second_p",       32'(o_out_p),   exp_b);
    check("bp.second_fix",     32'(o_out_fix), 32'd1);
    @(posedge clk); #1;
    check("bp.second_drop", 32'(o_out_valid), 32'd0);

    // Reset in the middle of an operation.
    in_valid = 1'b1; in_a = 12'd500; in_b = 12'd600;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort.busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", 32'(o_out_valid), 32'd0);
    check("abort.busy",      32'(o_busy),      32'd0);
    check("abort.out_p",     32'(o_out_p),     32'd0);
    check("abort.out_fix",   32'(o_out_fix),   32'd0);
    check("abort.in_ready",  32'(o_in_ready),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort.idle_valid", 32'(o_out_valid), 32'd0);
    run_op(17, 19, "post_abort");

    // RB=4 random regression.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom_range(0, 4095), $urandom_range(0, 4095), "rb4_rnd");
    end
    run_op(4095, 2776, "rb4_edge");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mulq_iter_2777.md
Name: mulq_iter_2777

Overview:
- Upstream feeder for the mod-2777 Barrett reduction stage.
- Accepts pairs of 12-bit operands over a valid/ready handshake and folds each operand into [0, 2776] with a single conditional subtract.
- Forms the full 23-bit product with an iterative shift-add datapath, then holds it on a valid/ready output.
- The output is the reducer's 23-bit input, so every emitted product is ≤ 2776² = 7,706,176 < 2^23.

Parameters:
- Q, 2777: modulus; operands are folded below Q.
- W, 12: operand width.
- PW, 23: product width, 2*W-1. Requires (Q-1)² < 2^PW.
- RB, 1: multiplier bits consumed per busy cycle. Legal values 1, 2, 3, 4, 6; RB must divide W.

Ports:
- clk       in   1   rising-edge clock
- rst_n     in   1   reset, asynchronous, active-low
- in_valid  in   1   operand pair valid
- in_ready  out  1   block can accept a pair
- in_a      in   W   operand A, 0..4095
- in_b      in   W   operand B, 0..4095
- out_valid out  1   product valid
- out_ready in   1   downstream accepts product
- out_p     out  PW  folded(A)*folded(B)
- out_fix   out  1   at least one operand needed folding
- busy      out  1   state == BUSY

Behaviour:
- Reset: rst_n low forces state IDLE immediately, asynchronously.
  - out_valid=0, out_p=0, out_fix=0, busy=0, internal acc/cnt=0.
  - in_ready=1 from the first rising edge after rst_n deasserts.
- Reset mid-operation: reset aborts the operation. The product is discarded and is never emitted.
- Fold rule, applied combinationally at accept: x' = (x ≥ Q) ? x−Q : x.
  - One subtract is sufficient because 4095 < 2Q.
  - out_fix = (in_a ≥ Q) | (in_b ≥ Q), registered at accept.
- FSM state IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load mcand=a' zero-extended to PW, mplier=b', acc=0, cnt=0, then go to BUSY.
- FSM state BUSY:
  - in_ready=0.
  - Each cycle: acc += mcand * mplier[RB-1:0]; mcand <<= RB; mplier >>= RB; cnt++.
  - When cnt reaches W/RB−1 (last digit), go to DONE with out_p = final acc.
- FSM state DONE:
  - out_valid=1; out_p and out_fix held stable until the transfer.
  - On out_ready: out_valid drops next cycle unless a new pair completes.
  - in_ready = out_ready, so a new pair may be accepted in the same cycle as the output transfer (back-to-back). That pair goes straight to BUSY.
  - If out_ready=1 and in_valid=0, go to IDLE.
- Latency:
  - Pair accepted at edge k → out_valid high after edge k+W/RB (12 cycles for RB=1, 3 for RB=4).
  - Sustained throughput: one product per W/RB+1 cycles.
- Width rules:
  - acc is PW bits; no intermediate exceeds PW.
  - The partial product mcand*digit is PW bits and is truncated. This is safe because the final value is below 2^PW.
- Input side: in_a/in_b are sampled only on the accept edge. Changes while in_valid is low, or during BUSY, are ignored.
- Output side:
  - out_p changes only on the transition into DONE.
  - The downstream stage may stall out_ready indefinitely. No data is lost, and no input is accepted during the stall.

Decomposition:
- Shared package mod2777_pkg holds:
  - Q, W, PW;
  - the product type (PW bits) and the residue type (W bits);
  - the FSM state enum {IDLE, BUSY, DONE}.
- The package is also used by the reduction stage so both ends agree on PW.
- One natural sub-module, fold_q: the combinational conditional subtract plus its ≥Q flag, instantiated once per operand.

Test Plan:
- Case 1, max folded operands: RB=1, in_a=2776, in_b=2776, out_ready=1 → out_valid after 12 cycles; out_p=7706176, out_fix=0.
- Case 2, folding both operands: in_a=3000, in_b=2 → out_p=446 (223*2), out_fix=1. Also in_a=4095, in_b=4095 → out_p=1737124 (1318²), out_fix=1.
- Case 3, zero and identity: in_a=0, in_b=1234 → out_p=0. Then in_a=1, in_b=1 → out_p=1. Both with out_fix=0 and correct order.
- Case 4, backpressure: out_ready=0 for 20 cycles after out_valid, in_valid held high → out_p stable, in_ready=0 throughout. Release out_ready → transfer, then the queued pair is accepted in the same cycle.
- Case 5, reset mid-operation: assert rst_n=0 at busy cycle 5 → out_valid, busy and out_p are 0 immediately. After release, 17*19 → out_p=323 with no stale output emitted.
- Case 6, RB=4 regression: 1000 random pairs with in_a, in_b in 0..4095 → latency 3 cycles; out_p equals the folded product against the model.
